bicubic_upsample_mc: RTL

//  4x bicubic upsampler for the image datapath: takes one 4x4 source window, emits a 4x4 output block, one row of 4 pixels per beat.

---
 rtl/bicubic_upsample_mc.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/bicubic_upsample_mc.sv
// 4x bicubic upsampler: one 4x4 multi-channel source window in, a 4x4 block out,
// one row of four pixels per response beat. Optional nearest-neighbour bypass.
module bicubic_upsample_mc #(
    parameter int unsigned CHANNEL_WIDTH = 8,
    parameter int unsigned CHANNELS      = 3
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    bf_req_valid,
    output logic                                    bcci_req_ready,
    input  logic [16*CHANNEL_WIDTH*CHANNELS-1:0]    bf_req_pixels,
    input  logic                                    bf_req_bypass,
    output logic [4*CHANNEL_WIDTH*CHANNELS-1:0]     bcci_rsp_data,
    output logic [1:0]                              bcci_rsp_row,
    output logic                                    bcci_rsp_last,
    output logic                                    bcci_rsp_valid,
    input  logic                                    bf_rsp_ready
);

    localparam int unsigned CW = CHANNEL_WIDTH;
    localparam int unsigned PW = CHANNEL_WIDTH * CHANNELS;
    localparam int unsigned TW = CHANNEL_WIDTH + 9;
    localparam int unsigned AW = CHANNEL_WIDTH + 17;
    localparam logic signed [AW-1:0] ROUND_HALF = AW'(8192);
    localparam logic signed [AW-1:0] CLAMP_MAX  = AW'((1 << CHANNEL_WIDTH) - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                  state;
    logic [16*PW-1:0]        window;
    logic                    bypass;
    logic [1:0]              row;
    logic [4*PW-1:0]         row_pixels;

    logic signed [TW-1:0]    t_val [4];
    logic signed [TW-1:0]    px;
    logic signed [TW-1:0]    wt;
    logic signed [AW-1:0]    acc;
    logic signed [AW-1:0]    rounded;
    logic [CW-1:0]           clamped;

    // Q7 bicubic phase weights; each phase sums to 128.
    function automatic logic signed [8:0] tap_weight(input logic [1:0] phase, input logic [1:0] tap);
        logic signed [8:0] w;
        w = 9'sd0;
        case (phase)
            2'd0: w = (tap == 2'd1) ? 9'sd128 : 9'sd0;
            2'd1: begin
                case (tap)
                    2'd0: w = -9'sd9;
                    2'd1: w = 9'sd111;
                    2'd2: w = 9'sd29;
                    default: w = -9'sd3;
                endcase
            end
            2'd2: begin
                case (tap)
                    2'd0: w = -9'sd8;
                    2'd1: w = 9'sd72;
                    2'd2: w = 9'sd72;
                    default: w = -9'sd8;
                endcase
            end
            default: begin
                case (tap)
                    2'd0: w = -9'sd3;
                    2'd1: w = 9'sd29;
                    2'd2: w = 9'sd111;
                    default: w = -9'sd9;
                endcase
            end
        endcase
        return w;
    endfunction

    // Ready is combinational on downstream ready so the next window can overlap the row-3 beat.
    assign bcci_req_ready = (state == IDLE) ||
                            ((state == OUT) && (row == 2'd3) && bf_rsp_ready);

    // Separable filter for the current row: vertical pass per column, horizontal per output pixel.
    always_comb begin
        row_pixels = '0;
        px         = '0;
        wt         = '0;
        acc        = '0;
        rounded    = '0;
        clamped    = '0;
        for (int k = 0; k < 4; k++) begin
            t_val[k] = '0;
        end
        for (int ch = 0; ch < int'(CHANNELS); ch++) begin
            for (int cc = 0; cc < 4; cc++) begin
                t_val[cc] = '0;
                for (int i = 0; i < 4; i++) begin
                    px = TW'({1'b0, window[(i*4 + cc)*PW + ch*CW +: CW]});
                    wt = TW'(tap_weight(row, 2'(i)));
                    t_val[cc] = t_val[cc] + wt * px;
                end
            end
            for (int j = 0; j < 4; j++) begin
                acc = '0;
                for (int cc = 0; cc < 4; cc++) begin
                    acc = acc + AW'(tap_weight(2'(j), 2'(cc))) * AW'(t_val[cc]);
                end
                rounded = (acc + ROUND_HALF) >>> 14;
                if (rounded[AW-1]) begin
                    clamped = '0;
                end else if (rounded > CLAMP_MAX) begin
                    clamped = '1;
                end else begin
                    clamped = CW'(rounded);
                end
                row_pixels[j*PW + ch*CW +: CW] = bypass ? window[5*PW + ch*CW +: CW] : clamped;
            end
        end
    end

    // Control FSM with registered response outputs; window captured on each request handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            window         <= '0;
            bypass         <= 1'b0;
            row            <= 2'd0;
            bcci_rsp_data  <= '0;
            bcci_rsp_row   <= 2'd0;
            bcci_rsp_last  <= 1'b0;
            bcci_rsp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bf_req_valid) begin
                        window <= bf_req_pixels;
                        bypass <= bf_req_bypass;
                        row    <= 2'd0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    bcci_rsp_data  <= row_pixels;
                    bcci_rsp_row   <= row;
                    bcci_rsp_last  <= (row == 2'd3);
                    bcci_rsp_valid <= 1'b1;
                    state          <= OUT;
                end
                OUT: begin
                    if (bf_rsp_ready) begin
                        bcci_rsp_valid <= 1'b0;
                        if (row != 2'd3) begin
                            row   <= row + 2'd1;
                            state <= CALC;
                        end else if (bf_req_valid) begin
                            window <= bf_req_pixels;
                            bypass <= bf_req_bypass;
                            row    <= 2'd0;
                            state  <= CALC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
